// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared funct codes, state encoding and constants for the divider issue logic
package alu_div_pkg;

    localparam logic [4:0] FUNCT_DIV  = 5'b10010;
    localparam logic [4:0] FUNCT_DIVU = 5'b10011;
    localparam logic [4:0] FUNCT_REM  = 5'b10100;
    localparam logic [4:0] FUNCT_REMU = 5'b10101;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WB,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/alu_div_special.sv
// rtl/alu_div_special.sv - combinational detect and result for requests that bypass the divider
module alu_div_special
    import alu_div_pkg::*;
(
    input  logic [4:0]  funct,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        is_special,
    output logic [31:0] special_res
);

    logic div_by_zero;
    logic overflow;

    assign div_by_zero = (op2 == 32'd0);
    assign overflow    = (op1 == INT_MIN) && (op2 == ALL_ONES);

    // Unknown funct codes complete immediately with a zero result.
    always_comb begin
        is_special  = 1'b1;
        special_res = 32'd0;
        case (funct)
            FUNCT_DIV: begin
                if (div_by_zero)   special_res = ALL_ONES;
                else if (overflow) special_res = INT_MIN;
                else               is_special  = 1'b0;
            end
            FUNCT_DIVU: begin
                if (div_by_zero) special_res = ALL_ONES;
                else             is_special  = 1'b0;
            end
            FUNCT_REM: begin
                if (div_by_zero)   special_res = op1;
                else if (overflow) special_res = 32'd0;
                else               is_special  = 1'b0;
            end
            FUNCT_REMU: begin
                if (div_by_zero) special_res = op1;
                else             is_special  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_div_issue.sv
// rtl/alu_div_issue.sv - issue/writeback controller between execute and the multi-cycle divider
module alu_div_issue
    import alu_div_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_funct_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic [4:0]  ex_rd_i,
    output logic        ex_ready_o,
    input  logic        flush_i,
    output logic        div_stb_o,
    output logic [4:0]  div_funct_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [31:0] div_res_i,
    input  logic        div_done_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    input  logic        wb_ready_i,
    output logic        err_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state;
    state_e        state_nx;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          is_special;
    logic [31:0]   special_res;
    logic          waiting;
    logic          timeout_hit;
    logic          timeout_evt;

    alu_div_special u_special (
        .funct       (ex_funct_i),
        .op1         (ex_op1_i),
        .op2         (ex_op2_i),
        .is_special  (is_special),
        .special_res (special_res)
    );

    // ex_ready_o is high exactly in IDLE, so it doubles as the accept qualifier.
    assign accept      = ex_valid_i & ex_ready_o & ~flush_i;
    assign waiting     = (state == ST_WAIT) || (state == ST_DRAIN);
    assign timeout_hit = (cnt == CNT_LAST);
    assign timeout_evt = waiting && !div_done_i && timeout_hit;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nx = is_special ? ST_WB : ST_ISSUE;
            end
            ST_ISSUE: begin
                state_nx = flush_i ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done_i)       state_nx = flush_i ? ST_IDLE : ST_WB;
                else if (timeout_hit) state_nx = ST_IDLE;
                else if (flush_i)     state_nx = ST_DRAIN;
            end
            ST_WB: begin
                if (flush_i || wb_ready_i) state_nx = ST_IDLE;
            end
            ST_DRAIN: begin
                if (div_done_i || timeout_hit) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state       <= ST_IDLE;
            ex_ready_o  <= 1'b1;
            div_stb_o   <= 1'b0;
            wb_valid_o  <= 1'b0;
            div_funct_o <= 5'd0;
            div_op1_o   <= 32'd0;
            div_op2_o   <= 32'd0;
            wb_rd_o     <= 5'd0;
            wb_data_o   <= 32'd0;
            cnt         <= '0;
            err_o       <= 1'b0;
        end else begin
            state      <= state_nx;
            ex_ready_o <= (state_nx == ST_IDLE);
            div_stb_o  <= (state_nx == ST_ISSUE);
            wb_valid_o <= (state_nx == ST_WB);

            if (accept) begin
                div_funct_o <= ex_funct_i;
                div_op1_o   <= ex_op1_i;
                div_op2_o   <= ex_op2_i;
                wb_rd_o     <= ex_rd_i;
                if (is_special) wb_data_o <= special_res;
            end

            if ((state == ST_WAIT) && div_done_i && !flush_i) wb_data_o <= div_res_i;

            if (state == ST_ISSUE) cnt <= '0;
            else if (waiting)      cnt <= cnt + CW'(1);

            if (timeout_evt) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_div_issue.sv
// tb/tb_alu_div_issue.sv - directed self-checking bench for alu_div_issue
module tb_alu_div_issue;

    localparam logic [4:0] F_DIV  = 5'b10010;
    localparam logic [4:0] F_DIVU = 5'b10011;
    localparam logic [4:0] F_REM  = 5'b10100;
    localparam logic [4:0] F_REMU = 5'b10101;

    logic        clk;
    logic        nReset;
    logic        ex_valid;
    logic [4:0]  ex_funct;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [4:0]  ex_rd;
    logic        ex_ready;
    logic        flush;
    logic        div_stb;
    logic [4:0]  div_funct;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [31:0] div_res;
    logic        div_done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        err;

    int n_asserts = 0;
    int n_fail    = 0;

    alu_div_issue #(.TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .ex_valid_i  (ex_valid),
        .ex_funct_i  (ex_funct),
        .ex_op1_i    (ex_op1),
        .ex_op2_i    (ex_op2),
        .ex_rd_i     (ex_rd),
        .ex_ready_o  (ex_ready),
        .flush_i     (flush),
        .div_stb_o   (div_stb),
        .div_funct_o (div_funct),
        .div_op1_o   (div_op1),
        .div_op2_o   (div_op2),
        .div_res_i   (div_res),
        .div_done_i  (div_done),
        .wb_valid_o  (wb_valid),
        .wb_rd_o     (wb_rd),
        .wb_data_o   (wb_data),
        .wb_ready_i  (wb_ready),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural divider used only to produce div_res_i for the normal path.
    function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            F_DIV:   return $signed(a) / $signed(b);
            F_DIVU:  return a / b;
            F_REM:   return $signed(a) % $signed(b);
            F_REMU:  return a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        ex_valid = 1'b1;
        ex_funct = f;
        ex_op1   = a;
        ex_op2   = b;
        ex_rd    = rd;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk({tag, "_wbv_after"}, 32'(wb_valid), 32'd0);
        chk({tag, "_rdy_after"}, 32'(ex_ready), 32'd1);
    endtask

    task automatic run_normal(input string tag, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input int lat, input logic [31:0] exp_data);
        int nstb;
        int nwb;
        do_issue(f, a, b, rd);
        chk({tag, "_stb"}, 32'(div_stb), 32'd1);
        chk({tag, "_op1"}, div_op1, a);
        chk({tag, "_op2"}, div_op2, b);
        chk({tag, "_funct"}, 32'(div_funct), 32'(f));
        nstb = 0;
        nwb  = 0;
        for (int i = 0; i < lat; i++) begin
            tick();
            if (div_stb)  nstb++;
            if (wb_valid) nwb++;
        end
        chk({tag, "_extra_stb"}, nstb, 0);
        chk({tag, "_early_wb"}, nwb, 0);
        div_done = 1'b1;
        div_res  = model(f, a, b);
        tick();
        div_done = 1'b0;
        div_res  = 32'hDEAD_BEEF;
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
        chk({tag, "_data"}, wb_data, exp_data);
        chk({tag, "_rd"}, 32'(wb_rd), 32'(rd));
        chk({tag, "_rdy_low"}, 32'(ex_ready), 32'd0);
        handshake(tag);
    endtask

    task automatic run_fast(input string tag, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [31:0] exp_data);
        do_issue(f, a, b, rd);
        chk({tag, "_no_stb"}, 32'(div_stb), 32'd0);
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
        chk({tag, "_data"}, wb_data, exp_data);
        chk({tag, "_rd"}, 32'(wb_rd), 32'(rd));
        chk({tag, "_rdy_low"}, 32'(ex_ready), 32'd0);
        handshake(tag);
    endtask

    initial begin
        nReset   = 1'b0;
        ex_valid = 1'b0;
        ex_funct = 5'd0;
        ex_op1   = 32'd0;
        ex_op2   = 32'd0;
        ex_rd    = 5'd0;
        flush    = 1'b0;
        div_res  = 32'd0;
        div_done = 1'b0;
        wb_ready = 1'b0;
        repeat (3) tick();

        chk("rst_ready", 32'(ex_ready), 32'd1);
        chk("rst_stb", 32'(div_stb), 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_rd", 32'(wb_rd), 32'd0);
        chk("rst_op1", div_op1, 32'd0);
        nReset = 1'b1;
        tick();

        run_normal("div", F_DIV, 32'h0000_0B9A, 32'h0000_000A, 5'd7, 34, 32'h0000_0129);
        run_normal("rem_pos", F_REM, 32'h0000_0129, 32'h0000_0010, 5'd12, 6, 32'h0000_0009);
        run_normal("rem_neg", F_REM, 32'hFFFF_FED7, 32'h0000_0010, 5'd31, 6, 32'hFFFF_FFF7);

        run_fast("divu_z", F_DIVU, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF);
        run_fast("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000);
        run_fast("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000);
        run_fast("remu_z", F_REMU, 32'h0000_1234, 32'd0, 5'd9, 32'h0000_1234);
        run_fast("bad_op", 5'b00001, 32'd7, 32'd3, 5'd2, 32'h0000_0000);

        do_issue(F_DIVU, 32'd5, 32'd0, 5'd3);
        for (int i = 0; i < 5; i++) begin
            chk("hold_wbv", 32'(wb_valid), 32'd1);
            chk("hold_data", wb_data, 32'hFFFF_FFFF);
            chk("hold_rdy", 32'(ex_ready), 32'd0);
            tick();
        end
        handshake("hold");

        do_issue(F_DIV, 32'd100, 32'd7, 5'd9);
        chk("flw_stb", 32'(div_stb), 32'd1);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("flw_drain_wbv", 32'(wb_valid), 32'd0);
            chk("flw_drain_rdy", 32'(ex_ready), 32'd0);
            tick();
        end
        div_done = 1'b1;
        div_res  = 32'h0000_000E;
        tick();
        div_done = 1'b0;
        chk("flw_rdy_back", 32'(ex_ready), 32'd1);
        chk("flw_no_wb", 32'(wb_valid), 32'd0);
        tick();
        chk("flw_no_wb2", 32'(wb_valid), 32'd0);
        run_normal("after_flw", F_DIVU, 32'd100, 32'd7, 5'd10, 5, 32'h0000_000E);

        do_issue(F_DIV, 32'd50, 32'd5, 5'd11);
        repeat (2) tick();
        flush    = 1'b1;
        div_done = 1'b1;
        div_res  = 32'd10;
        tick();
        flush    = 1'b0;
        div_done = 1'b0;
        chk("flw_done_rdy", 32'(ex_ready), 32'd1);
        chk("flw_done_wbv", 32'(wb_valid), 32'd0);

        do_issue(F_DIV, 32'd1, 32'd0, 5'd13);
        chk("flwb_wbv", 32'(wb_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flwb_drop", 32'(wb_valid), 32'd0);
        chk("flwb_rdy", 32'(ex_ready), 32'd1);

        ex_valid = 1'b1;
        ex_funct = F_DIVU;
        ex_op1   = 32'h5555_5555;
        ex_op2   = 32'd3;
        flush    = 1'b1;
        tick();
        ex_valid = 1'b0;
        flush    = 1'b0;
        chk("fli_rdy", 32'(ex_ready), 32'd1);
        chk("fli_stb", 32'(div_stb), 32'd0);
        chk("fli_wbv", 32'(wb_valid), 32'd0);
        chk("fli_op1_held", div_op1, 32'd1);

        div_done = 1'b1;
        div_res  = 32'h1111_1111;
        tick();
        div_done = 1'b0;
        chk("idle_done_wbv", 32'(wb_valid), 32'd0);

        do_issue(F_DIV, 32'd10, 32'd2, 5'd14);
        chk("to_stb", 32'(div_stb), 32'd1);
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("to_wait_rdy", 32'(ex_ready), 32'd0);
            chk("to_wait_err", 32'(err), 32'd0);
        end
        tick();
        chk("to_err", 32'(err), 32'd1);
        chk("to_rdy", 32'(ex_ready), 32'd1);
        chk("to_wbv", 32'(wb_valid), 32'd0);
        div_done = 1'b1;
        div_res  = 32'd5;
        tick();
        div_done = 1'b0;
        chk("to_late_wbv", 32'(wb_valid), 32'd0);
        chk("to_err_sticky", 32'(err), 32'd1);
        nReset = 1'b0;
        tick();
        chk("to_err_clr", 32'(err), 32'd0);
        nReset = 1'b1;
        tick();

        do_issue(F_DIV, 32'd9, 32'd3, 5'd15);
        chk("arst_pre_stb", 32'(div_stb), 32'd1);
        nReset = 1'b0;
        #1;
        chk("arst_stb", 32'(div_stb), 32'd0);
        chk("arst_rdy", 32'(ex_ready), 32'd1);
        tick();
        nReset = 1'b1;
        tick();
        run_normal("post_rst", F_REMU, 32'd17, 32'd5, 5'd1, 3, 32'h0000_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
